// File: rtl/gate_sequencer_pkg.sv
// Shared types and constants for the per-lane gate sequencer.
package gate_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_AUTH = 3'd1,
        ST_OPENING   = 3'd2,
        ST_OPEN      = 3'd3,
        ST_CLOSING   = 3'd4
    } lane_state_e;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    localparam int STATUS_ENTRY_BIT = 0;
    localparam int STATUS_EXIT_BIT  = 1;

endpackage

// File: rtl/gate_sequencer_if.sv
// Lane sensor inputs, barrier commands and status outputs of the gate sequencer.
interface gate_sequencer_if #(parameter int CNT_W = 8);
    import gate_sequencer_pkg::*;

    logic             entry_loop, entry_auth, entry_pass;
    logic             exit_loop, exit_auth, exit_pass;
    logic             emergency_in;
    logic [1:0]       barrier_status;
    logic             open_entry, close_entry, open_exit, close_exit;
    logic             vehicle_direction, emergency;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full, full_reject;
    logic             entry_fault, exit_fault;
    lane_state_e      entry_state, exit_state;

    // Events are level/pulse samples; no valid/ready handshake, every signal is taken each cycle.
    modport master (
        output entry_loop, entry_auth, entry_pass, exit_loop, exit_auth, exit_pass,
               emergency_in, barrier_status,
        input  open_entry, close_entry, open_exit, close_exit, vehicle_direction,
               emergency, occupancy, lot_full, full_reject, entry_fault, exit_fault,
               entry_state, exit_state
    );

    modport slave (
        input  entry_loop, entry_auth, entry_pass, exit_loop, exit_auth, exit_pass,
               emergency_in, barrier_status,
        output open_entry, close_entry, open_exit, close_exit, vehicle_direction,
               emergency, occupancy, lot_full, full_reject, entry_fault, exit_fault,
               entry_state, exit_state
    );

endinterface

// File: rtl/gate_sequencer_lane.sv
// One lane's barrier FSM: timer, registered open/close pulses, sticky fault.
module gate_lane_fsm
    import gate_sequencer_pkg::*;
#(
    parameter int OPEN_TIMEOUT  = 32,
    parameter int PASS_TIMEOUT  = 1000,
    parameter int CLOSE_TIMEOUT = 16,
    parameter int TMR_W         = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loop_i,
    input  logic        auth_i,
    input  logic        pass_i,
    input  logic        status_i,
    input  logic        gate_en_i,
    input  logic        full_i,
    input  logic        force_idle_i,
    input  logic        recover_i,
    output logic        open_o,
    output logic        close_o,
    output logic        reject_o,
    output logic        fault_o,
    output logic        open_evt_o,
    output logic        pass_evt_o,
    output lane_state_e state_o
);

    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PASS_LAST  = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_TIMEOUT - 1);

    lane_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             open_q, open_d, close_q, close_d;
    logic             reject_q, reject_d, fault_q, fault_d;
    logic             pass_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            open_q   <= 1'b0;
            close_q  <= 1'b0;
            reject_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            open_q   <= open_d;
            close_q  <= close_d;
            reject_q <= reject_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        open_d   = 1'b0;
        close_d  = 1'b0;
        reject_d = 1'b0;
        fault_d  = fault_q;
        pass_evt = 1'b0;
        if (force_idle_i) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else if (recover_i) begin
            state_d = ST_CLOSING;
            timer_d = '0;
            close_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (loop_i) state_d = ST_WAIT_AUTH;
                end
                ST_WAIT_AUTH: begin
                    timer_d = '0;
                    if (!loop_i) begin
                        state_d = ST_IDLE;
                    end else if (auth_i) begin
                        if (gate_en_i && full_i) begin
                            reject_d = 1'b1;
                        end else begin
                            open_d  = 1'b1;
                            state_d = ST_OPENING;
                        end
                    end
                end
                ST_OPENING: begin
                    if (status_i) begin
                        state_d = ST_OPEN;
                        timer_d = '0;
                    end else if (timer_q == OPEN_LAST) begin
                        fault_d = 1'b1;
                        close_d = 1'b1;
                        state_d = ST_CLOSING;
                        timer_d = '0;
                    end
                end
                ST_OPEN: begin
                    if (pass_i || timer_q == PASS_LAST) begin
                        pass_evt = pass_i;
                        close_d  = 1'b1;
                        state_d  = ST_CLOSING;
                        timer_d  = '0;
                    end
                end
                ST_CLOSING: begin
                    if (!status_i) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (timer_q == CLOSE_LAST) begin
                        fault_d = 1'b1;
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign open_o     = open_q;
    assign close_o    = close_q;
    assign reject_o   = reject_q;
    assign fault_o    = fault_q;
    assign open_evt_o = open_d;
    assign pass_evt_o = pass_evt;
    assign state_o    = state_q;

endmodule

// File: rtl/gate_sequencer.sv
// Two-lane gate sequencer: occupancy, direction, emergency hold and recovery close.
module gate_sequencer
    import gate_sequencer_pkg::*;
#(
    parameter int CAPACITY      = 100,
    parameter int CNT_W         = 8,
    parameter int OPEN_TIMEOUT  = 32,
    parameter int PASS_TIMEOUT  = 1000,
    parameter int CLOSE_TIMEOUT = 16,
    parameter int TMR_W         = 10
) (
    input  logic            clk,
    input  logic            reset,
    gate_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic             emerg_q, emerg_prev_q;
    logic             dir_q, dir_d;
    logic             lot_full_q;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             force_idle, recover;
    logic             ent_open_evt, ext_open_evt, ent_pass_evt, ext_pass_evt;
    logic             ent_reject, ext_reject;

    // Lanes are held idle from the first sampled request; the recovery close lands one
    // cycle after the registered emergency drops.
    assign force_idle = bus.emergency_in | emerg_q;
    assign recover    = emerg_prev_q & ~emerg_q & ~bus.emergency_in;

    gate_lane_fsm #(
        .OPEN_TIMEOUT(OPEN_TIMEOUT), .PASS_TIMEOUT(PASS_TIMEOUT),
        .CLOSE_TIMEOUT(CLOSE_TIMEOUT), .TMR_W(TMR_W)
    ) u_entry (
        .clk(clk), .reset(reset),
        .loop_i(bus.entry_loop), .auth_i(bus.entry_auth), .pass_i(bus.entry_pass),
        .status_i(bus.barrier_status[STATUS_ENTRY_BIT]),
        .gate_en_i(1'b1), .full_i(lot_full_q),
        .force_idle_i(force_idle), .recover_i(recover),
        .open_o(bus.open_entry), .close_o(bus.close_entry), .reject_o(ent_reject),
        .fault_o(bus.entry_fault), .open_evt_o(ent_open_evt), .pass_evt_o(ent_pass_evt),
        .state_o(bus.entry_state)
    );

    gate_lane_fsm #(
        .OPEN_TIMEOUT(OPEN_TIMEOUT), .PASS_TIMEOUT(PASS_TIMEOUT),
        .CLOSE_TIMEOUT(CLOSE_TIMEOUT), .TMR_W(TMR_W)
    ) u_exit (
        .clk(clk), .reset(reset),
        .loop_i(bus.exit_loop), .auth_i(bus.exit_auth), .pass_i(bus.exit_pass),
        .status_i(bus.barrier_status[STATUS_EXIT_BIT]),
        .gate_en_i(1'b0), .full_i(lot_full_q),
        .force_idle_i(force_idle), .recover_i(recover),
        .open_o(bus.open_exit), .close_o(bus.close_exit), .reject_o(ext_reject),
        .fault_o(bus.exit_fault), .open_evt_o(ext_open_evt), .pass_evt_o(ext_pass_evt),
        .state_o(bus.exit_state)
    );

    always_comb begin
        occ_d = occ_q;
        if (ent_pass_evt && !ext_pass_evt && occ_q != CAP) begin
            occ_d = occ_q + 1'b1;
        end else if (ext_pass_evt && !ent_pass_evt && occ_q != '0) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_comb begin
        dir_d = dir_q;
        if (ent_open_evt)      dir_d = DIR_ENTRY;
        else if (ext_open_evt) dir_d = DIR_EXIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            emerg_q      <= 1'b0;
            emerg_prev_q <= 1'b0;
            dir_q        <= DIR_ENTRY;
            occ_q        <= '0;
            lot_full_q   <= 1'b0;
        end else begin
            emerg_q      <= bus.emergency_in;
            emerg_prev_q <= emerg_q;
            dir_q        <= dir_d;
            occ_q        <= occ_d;
            lot_full_q   <= (occ_d == CAP);
        end
    end

    assign bus.emergency         = emerg_q;
    assign bus.vehicle_direction = dir_q;
    assign bus.occupancy         = occ_q;
    assign bus.lot_full          = lot_full_q;
    assign bus.full_reject       = ent_reject | ext_reject;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: lane flows, timeouts, full lot, emergency.
module tb_gate_sequencer;
    import gate_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;

    gate_sequencer_if #(.CNT_W(8)) bus ();

    gate_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ex, input logic loop, input logic auth,
                         input logic pass, input logic st);
        if (ex) begin
            bus.exit_loop = loop; bus.exit_auth = auth; bus.exit_pass = pass;
            bus.barrier_status[1] = st;
        end else begin
            bus.entry_loop = loop; bus.entry_auth = auth; bus.entry_pass = pass;
            bus.barrier_status[0] = st;
        end
    endtask

    task automatic lane_cycle(input bit ex);
        drive(ex, 1, 0, 0, 0); tick();
        drive(ex, 1, 1, 0, 0); tick();
        drive(ex, 1, 0, 0, 1); tick();
        drive(ex, 1, 0, 1, 1); tick();
        drive(ex, 0, 0, 0, 0); tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.emergency_in = 1'b0;
        bus.barrier_status = 2'b00;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_occ", 32'(bus.occupancy), 0);
        chk("rst_open_entry", 32'(bus.open_entry), 0);
        chk("rst_faults", 32'({bus.entry_fault, bus.exit_fault}), 0);
        chk("rst_state", 32'(bus.entry_state), 32'(ST_IDLE));
        reset = 1'b0;
        tick();

        // exit at empty lot saturates at zero
        lane_cycle(1);
        chk("exit_at_zero_occ", 32'(bus.occupancy), 0);
        chk("exit_dir", 32'(bus.vehicle_direction), 1);

        // normal entry
        drive(0, 1, 0, 0, 0); tick();
        chk("entry_wait", 32'(bus.entry_state), 32'(ST_WAIT_AUTH));
        drive(0, 1, 1, 0, 0); tick();
        chk("entry_open_pulse", 32'(bus.open_entry), 1);
        chk("entry_dir", 32'(bus.vehicle_direction), 0);
        drive(0, 1, 0, 0, 1); tick();
        chk("entry_open_1cyc", 32'(bus.open_entry), 0);
        chk("entry_state_open", 32'(bus.entry_state), 32'(ST_OPEN));
        drive(0, 1, 0, 1, 1); tick();
        chk("entry_close_pulse", 32'(bus.close_entry), 1);
        chk("entry_occ", 32'(bus.occupancy), 1);
        drive(0, 0, 0, 0, 0); tick();
        chk("entry_close_1cyc", 32'(bus.close_entry), 0);
        chk("entry_back_idle", 32'(bus.entry_state), 32'(ST_IDLE));
        tick();

        repeat (5) lane_cycle(0);
        lane_cycle(1);
        chk("occ_five", 32'(bus.occupancy), 5);
        chk("dir_exit", 32'(bus.vehicle_direction), 1);

        // both lanes open and pass together
        drive(0, 1, 0, 0, 0); drive(1, 1, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0); drive(1, 1, 1, 0, 0); tick();
        chk("sim_open_both", 32'({bus.open_entry, bus.open_exit}), 3);
        chk("sim_dir_entry", 32'(bus.vehicle_direction), 0);
        drive(0, 1, 0, 0, 1); drive(1, 1, 0, 0, 1); tick();
        drive(0, 1, 0, 1, 1); drive(1, 1, 0, 1, 1); tick();
        chk("sim_close_both", 32'({bus.close_entry, bus.close_exit}), 3);
        chk("sim_occ_hold", 32'(bus.occupancy), 5);
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); tick(); tick();

        // exit open timeout, then close timeout with barrier stuck open
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 0); tick();
        chk("ot_open_pulse", 32'(bus.open_exit), 1);
        drive(1, 1, 0, 0, 0);
        repeat (31) tick();
        chk("ot_fault_before", 32'(bus.exit_fault), 0);
        chk("ot_state_opening", 32'(bus.exit_state), 32'(ST_OPENING));
        tick();
        chk("ot_fault", 32'(bus.exit_fault), 1);
        chk("ot_close_pulse", 32'(bus.close_exit), 1);
        chk("ot_state_closing", 32'(bus.exit_state), 32'(ST_CLOSING));
        bus.barrier_status[1] = 1'b1;
        repeat (15) tick();
        chk("ct_still_closing", 32'(bus.exit_state), 32'(ST_CLOSING));
        tick();
        chk("ct_idle", 32'(bus.exit_state), 32'(ST_IDLE));
        drive(1, 0, 0, 0, 0); tick();

        // pass timeout in OPEN
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 0); tick();
        drive(1, 1, 0, 0, 1); tick();
        repeat (999) tick();
        chk("pt_no_close_yet", 32'(bus.close_exit), 0);
        chk("pt_state_open", 32'(bus.exit_state), 32'(ST_OPEN));
        tick();
        chk("pt_close_pulse", 32'(bus.close_exit), 1);
        chk("pt_occ_hold", 32'(bus.occupancy), 5);
        drive(1, 0, 0, 0, 0); tick(); tick();

        // emergency during entry OPENING
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        chk("em_open_pulse", 32'(bus.open_entry), 1);
        drive(0, 1, 0, 0, 0); tick();
        bus.emergency_in = 1'b1; tick();
        chk("em_flag", 32'(bus.emergency), 1);
        chk("em_forced_idle", 32'(bus.entry_state), 32'(ST_IDLE));
        drive(0, 1, 1, 0, 0); tick();
        chk("em_no_open", 32'(bus.open_entry), 0);
        chk("em_still_idle", 32'(bus.entry_state), 32'(ST_IDLE));
        drive(0, 1, 0, 0, 0);
        bus.emergency_in = 1'b0; tick();
        chk("em_flag_off", 32'(bus.emergency), 0);
        chk("em_no_close_yet", 32'({bus.close_entry, bus.close_exit}), 0);
        tick();
        chk("em_recover_close", 32'({bus.close_entry, bus.close_exit}), 3);
        chk("em_entry_closing", 32'(bus.entry_state), 32'(ST_CLOSING));
        chk("em_exit_closing", 32'(bus.exit_state), 32'(ST_CLOSING));
        chk("em_fault_hold", 32'({bus.entry_fault, bus.exit_fault}), 1);
        chk("em_occ_hold", 32'(bus.occupancy), 5);
        drive(0, 0, 0, 0, 0); tick();
        chk("em_close_1cyc", 32'(bus.close_entry), 0);
        chk("em_idle", 32'(bus.entry_state), 32'(ST_IDLE));
        tick();

        // fill the lot and try one more entry
        repeat (95) lane_cycle(0);
        chk("full_occ", 32'(bus.occupancy), 100);
        chk("full_flag", 32'(bus.lot_full), 1);
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        chk("full_reject_pulse", 32'(bus.full_reject), 1);
        chk("full_no_open", 32'(bus.open_entry), 0);
        chk("full_wait", 32'(bus.entry_state), 32'(ST_WAIT_AUTH));
        drive(0, 1, 0, 0, 0); tick();
        chk("full_reject_1cyc", 32'(bus.full_reject), 0);
        drive(0, 0, 0, 0, 0); tick();
        lane_cycle(1);
        chk("after_exit_occ", 32'(bus.occupancy), 99);
        chk("after_exit_not_full", 32'(bus.lot_full), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_sequencer.md
Name: gate_sequencer

Overview:
Per-lane vehicle flow controller that sits directly upstream of the barrier controller. It turns loop-detector, ticket-authorisation and pass-beam events into single-cycle open/close commands, plus the vehicle_direction and emergency signals. It watches barrier_status feedback, applies timeouts, and tracks lot occupancy so entry is refused when the lot is full.

Parameters:
CAPACITY, 100, number of spaces; occupancy saturates here.
CNT_W, 8, occupancy width; must satisfy 2**CNT_W > CAPACITY.
OPEN_TIMEOUT, 32, cycles in OPENING before fault; must exceed the barrier open delay + 2.
PASS_TIMEOUT, 1000, cycles in OPEN with no pass event before auto-close.
CLOSE_TIMEOUT, 16, cycles in CLOSING before fault.
TMR_W, 10, timeout counter width; holds the largest timeout.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
entry_loop  in  1  vehicle present at entry loop (level)
entry_auth  in  1  valid ticket, single-cycle pulse
entry_pass  in  1  vehicle cleared entry beam, pulse
exit_loop  in  1  vehicle present at exit loop (level)
exit_auth  in  1  valid exit payment, pulse
exit_pass  in  1  vehicle cleared exit beam, pulse
emergency_in  in  1  raw emergency request (level)
barrier_status  in  2  feedback: bit0 entry open, bit1 exit open
open_entry, close_entry, open_exit, close_exit  out  1 each  command pulses to the barrier controller
vehicle_direction  out  1  0 entry, 1 exit
emergency  out  1  registered emergency_in
occupancy  out  CNT_W  vehicles inside
lot_full  out  1  occupancy == CAPACITY
full_reject  out  1  pulse: entry auth refused because the lot is full
entry_fault, exit_fault  out  1 each  sticky barrier timeout flags

Behaviour:
- Reset clears every output, occupancy, timers and faults to 0; both lane FSMs go to IDLE.
- All outputs are registered. Command pulses are exactly 1 cycle wide and occur the cycle after the triggering event is sampled.
- Each lane runs its own FSM with states IDLE, WAIT_AUTH, OPENING, OPEN, CLOSING. Bits and signals below are per lane.
- IDLE: loop=1 -> WAIT_AUTH.
- WAIT_AUTH:
  - loop=0 -> IDLE.
  - auth=1 -> open pulse, timer cleared, go to OPENING. This is gated on entry by lot_full==0.
  - Entry auth with lot_full=1 -> full_reject pulse; stay in WAIT_AUTH.
- OPENING:
  - status bit=1 -> OPEN, timer cleared.
  - Timer reaches OPEN_TIMEOUT -> set fault, close pulse, go to CLOSING.
- OPEN:
  - pass=1 -> close pulse, occupancy update, go to CLOSING.
  - Timer reaches PASS_TIMEOUT -> close pulse, go to CLOSING, occupancy unchanged.
- CLOSING:
  - status bit=0 -> IDLE.
  - Timer reaches CLOSE_TIMEOUT -> set fault, go to IDLE.
- auth, pass and status events outside the states listed above are ignored.
- Timers count only in OPENING, OPEN and CLOSING, and clear on every state change.
- Occupancy:
  - entry_pass accepted -> +1, saturating at CAPACITY.
  - exit_pass accepted -> -1, saturating at 0.
  - Both accepted in the same cycle -> no change.
- vehicle_direction updates with each open pulse: entry -> 0, exit -> 1. If both lanes issue open in the same cycle, it is set to 0. Otherwise it holds.
- emergency = emergency_in delayed 1 cycle. While emergency=1:
  - both FSMs are forced to IDLE and timers clear;
  - all command pulses are suppressed;
  - occupancy and faults hold.
- On the first cycle after emergency falls 1->0, issue close_entry and close_exit together and put both FSMs in CLOSING.
- Faults are sticky and cleared only by reset.
- Reset mid-operation aborts everything immediately. No close pulse is issued.

Decomposition:
- Shared package: lane state enum (IDLE, WAIT_AUTH, OPENING, OPEN, CLOSING), direction constants DIR_ENTRY=0 and DIR_EXIT=1, and barrier_status bit indices.
- One sub-module, gate_lane_fsm, instantiated twice (entry, exit). It holds the FSM, timer, command pulses and fault. A gate_input on the entry instance enables lot_full gating.
- The top level holds occupancy, direction, emergency registration and the recovery close.

Test Plan:
- Normal entry: entry_loop=1, entry_auth pulse at cycle 5 -> open_entry high at cycle 6 only. Drive barrier_status=01 -> OPEN. entry_pass -> close_entry pulse next cycle, occupancy 0->1, vehicle_direction=0.
- Full lot: preload occupancy to CAPACITY=100 via passes; entry_auth -> full_reject pulse, no open_entry, lot_full=1. A subsequent exit cycle drops occupancy to 99 and lot_full to 0.
- Open timeout: after open_exit, hold barrier_status=00 for 32 cycles -> exit_fault=1, close_exit pulse, FSM in CLOSING. After CLOSE_TIMEOUT the FSM returns to IDLE.
- Pass timeout: barrier open, no exit_pass for 1000 cycles -> close_exit pulse; occupancy unchanged.
- Emergency: assert emergency_in mid-OPENING -> emergency=1 next cycle, no command pulses. Deassert -> one cycle later close_entry=close_exit=1 together.
- Simultaneous: entry_pass and exit_pass in the same cycle at occupancy 5 -> occupancy stays 5. Exit pass at occupancy 0 -> stays 0.
